// File: rtl/eng_outbuf.sv
// Output buffer behind the encoding engine: stores whole parity groups in a flop FIFO
// and streams them out one packet per beat on a valid/ready interface.
module eng_outbuf #(
    parameter int unsigned PacketLength       = 32,
    parameter int unsigned W                  = 8,
    parameter int unsigned PckTreeXorUnitsNum = 2,
    parameter int unsigned OutbufDepth        = 4,
    localparam int unsigned CntW              = $clog2(OutbufDepth + 1)
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_i,
    input  logic                                                  cntl_outbuf_clr_i,
    input  logic [0:W-1][0:PckTreeXorUnitsNum-1][PacketLength-1:0] eng_outbuf_dout_reg_i,
    input  logic                                                  eng_outbuf_wr_req_i,
    output logic                                                  outbuf_eng_wr_ack_o,
    output logic                                                  outbuf_eng_full_o,
    output logic [PacketLength-1:0]                               outbuf_dout_o,
    output logic                                                  outbuf_dout_val_o,
    output logic                                                  outbuf_dout_last_o,
    input  logic                                                  outbuf_dout_rdy_i,
    output logic                                                  outbuf_cntl_empty_o,
    output logic [CntW-1:0]                                       outbuf_cntl_cnt_o
);

    localparam int unsigned PtrW  = (OutbufDepth > 1) ? $clog2(OutbufDepth) : 1;
    localparam int unsigned BitW  = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned UnitW = (PckTreeXorUnitsNum > 1) ? $clog2(PckTreeXorUnitsNum) : 1;

    typedef logic [0:W-1][0:PckTreeXorUnitsNum-1][PacketLength-1:0] group_t;

    group_t            mem_q [OutbufDepth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [BitW-1:0]   bit_idx_q, bit_idx_d;
    logic [UnitW-1:0]  unit_idx_q, unit_idx_d;

    logic full, empty, ack, xfer, last, pop;

    // Pointers wrap at OutbufDepth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(OutbufDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full  = (cnt_q == CntW'(OutbufDepth));
    assign empty = (cnt_q == '0);
    assign ack   = eng_outbuf_wr_req_i & ~full & ~cntl_outbuf_clr_i & ~rst_i;
    assign last  = ~empty & (unit_idx_q == UnitW'(PckTreeXorUnitsNum - 1))
                          & (bit_idx_q == BitW'(W - 1));
    assign xfer  = ~empty & outbuf_dout_rdy_i;
    assign pop   = xfer & last;

    assign outbuf_eng_wr_ack_o  = ack;
    assign outbuf_eng_full_o    = full;
    assign outbuf_cntl_empty_o  = empty;
    assign outbuf_cntl_cnt_o    = cnt_q;
    assign outbuf_dout_val_o    = ~empty;
    assign outbuf_dout_last_o   = last;
    assign outbuf_dout_o        = empty ? '0 : mem_q[rd_ptr_q][bit_idx_q][unit_idx_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        unit_idx_d = unit_idx_q;
        if (cntl_outbuf_clr_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            bit_idx_d  = '0;
            unit_idx_d = '0;
        end else begin
            if (ack) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (xfer) begin
                if (last) begin
                    bit_idx_d  = '0;
                    unit_idx_d = '0;
                    rd_ptr_d   = ptr_inc(rd_ptr_q);
                end else if (bit_idx_q == BitW'(W - 1)) begin
                    bit_idx_d  = '0;
                    unit_idx_d = unit_idx_q + UnitW'(1);
                end else begin
                    bit_idx_d  = bit_idx_q + BitW'(1);
                end
            end
            case ({ack, pop})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            unit_idx_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            unit_idx_q <= unit_idx_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (ack) begin
            mem_q[wr_ptr_q] <= eng_outbuf_dout_reg_i;
        end
    end

endmodule

// File: tb/tb_eng_outbuf.sv
// Self-checking bench for eng_outbuf: two instances (depth 4 and 3) checked every cycle
// against a queue-of-groups model, plus table-driven and hand-written corner sequences.
module tb_eng_outbuf;

    localparam int unsigned PL    = 32;
    localparam int unsigned W     = 8;
    localparam int unsigned N     = 2;
    localparam int unsigned BEATS = W * N;

    typedef logic [0:W-1][0:N-1][PL-1:0] group_t;

    typedef struct {
        logic          wr;
        logic          rdy;
        logic          e_ack;
        logic          e_full;
        logic          e_val;
        logic          e_last;
        logic [PL-1:0] e_dout;
        int            e_cnt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, clr, rdy;
    logic          wr_req [2];
    group_t        din    [2];
    logic          ack    [2];
    logic          full   [2];
    logic          val    [2];
    logic          last   [2];
    logic          empty  [2];
    logic [PL-1:0] dout   [2];
    logic [2:0]    cnt4;
    logic [1:0]    cnt3;

    eng_outbuf #(.PacketLength(PL), .W(W), .PckTreeXorUnitsNum(N), .OutbufDepth(4)) u_dut4 (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .cntl_outbuf_clr_i     (clr),
        .eng_outbuf_dout_reg_i (din[0]),
        .eng_outbuf_wr_req_i   (wr_req[0]),
        .outbuf_eng_wr_ack_o   (ack[0]),
        .outbuf_eng_full_o     (full[0]),
        .outbuf_dout_o         (dout[0]),
        .outbuf_dout_val_o     (val[0]),
        .outbuf_dout_last_o    (last[0]),
        .outbuf_dout_rdy_i     (rdy),
        .outbuf_cntl_empty_o   (empty[0]),
        .outbuf_cntl_cnt_o     (cnt4)
    );

    eng_outbuf #(.PacketLength(PL), .W(W), .PckTreeXorUnitsNum(N), .OutbufDepth(3)) u_dut3 (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .cntl_outbuf_clr_i     (clr),
        .eng_outbuf_dout_reg_i (din[1]),
        .eng_outbuf_wr_req_i   (wr_req[1]),
        .outbuf_eng_wr_ack_o   (ack[1]),
        .outbuf_eng_full_o     (full[1]),
        .outbuf_dout_o         (dout[1]),
        .outbuf_dout_val_o     (val[1]),
        .outbuf_dout_last_o    (last[1]),
        .outbuf_dout_rdy_i     (rdy),
        .outbuf_cntl_empty_o   (empty[1]),
        .outbuf_cntl_cnt_o     (cnt3)
    );

    // Reference model: a queue of whole groups plus the beat position inside the head group.
    group_t q0[$];
    group_t q1[$];
    int     pos  [2];
    int     pops [2];
    int     n_tests = 0;
    int     n_fail  = 0;

    logic          s_ack   [2];
    logic          s_full  [2];
    logic          s_val   [2];
    logic          s_last  [2];
    logic          s_empty [2];
    logic [PL-1:0] s_dout  [2];
    int            s_cnt   [2];

    function automatic int depth_of(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    function automatic int msize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic group_t mfront(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    function automatic group_t rand_group();
        group_t g;
        for (int b = 0; b < W; b++)
            for (int u = 0; u < N; u++) g[b][u] = $urandom;
        return g;
    endfunction

    function automatic group_t tag_group(input int k);
        group_t g;
        for (int b = 0; b < W; b++)
            for (int u = 0; u < N; u++) g[b][u] = PL'((k << 8) | (u << 4) | b);
        return g;
    endfunction

    task automatic cmp(input string name, input int i, input logic [PL-1:0] act,
                       input logic [PL-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s depth%0d @%0t: got 0x%0h, expected 0x%0h",
                     name, depth_of(i), $time, act, exp);
        end
    endtask

    task automatic check_inst(input int i);
        int            sz;
        logic          e_val, e_full, e_ack, e_last;
        logic [PL-1:0] e_dout;
        group_t        g;
        sz     = msize(i);
        e_val  = (sz != 0);
        e_full = (sz == depth_of(i));
        e_ack  = wr_req[i] && !clr && !rst && !e_full;
        e_last = e_val && (pos[i] == BEATS - 1);
        e_dout = '0;
        if (e_val) begin
            g      = mfront(i);
            e_dout = g[pos[i] % W][pos[i] / W];
        end
        s_ack[i]   = ack[i];
        s_full[i]  = full[i];
        s_val[i]   = val[i];
        s_last[i]  = last[i];
        s_empty[i] = empty[i];
        s_dout[i]  = dout[i];
        s_cnt[i]   = (i == 0) ? int'(cnt4) : int'(cnt3);
        cmp("ack",   i, PL'(s_ack[i]),   PL'(e_ack));
        cmp("full",  i, PL'(s_full[i]),  PL'(e_full));
        cmp("empty", i, PL'(s_empty[i]), PL'(!e_val));
        cmp("cnt",   i, PL'(s_cnt[i]),   PL'(sz));
        cmp("val",   i, PL'(s_val[i]),   PL'(e_val));
        cmp("last",  i, PL'(s_last[i]),  PL'(e_last));
        cmp("dout",  i, s_dout[i],       e_dout);
    endtask

    task automatic update_inst(input int i);
        int   sz;
        logic e_ack;
        sz    = msize(i);
        e_ack = wr_req[i] && !clr && !rst && (sz != depth_of(i));
        if (rst || clr) begin
            if (i == 0) q0.delete(); else q1.delete();
            pos[i] = 0;
        end else begin
            if (sz != 0 && rdy) begin
                if (pos[i] == BEATS - 1) begin
                    if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    pos[i] = 0;
                    pops[i]++;
                end else begin
                    pos[i]++;
                end
            end
            if (e_ack) begin
                if (i == 0) q0.push_back(din[i]); else q1.push_back(din[i]);
            end
        end
    endtask

    // Inputs are set just after a posedge; outputs are sampled on the following negedge.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) check_inst(i);
        @(posedge clk);
        for (int i = 0; i < 2; i++) update_inst(i);
        #1;
    endtask

    task automatic set_in(input logic wr, input logic r, input logic c);
        wr_req[0] = wr;
        wr_req[1] = wr;
        rdy       = r;
        clr       = c;
    endtask

    task automatic drain();
        int n;
        set_in(1'b0, 1'b1, 1'b0);
        n = 0;
        while ((msize(0) != 0 || msize(1) != 0) && n < 300) begin
            step();
            n++;
        end
        step();
        for (int i = 0; i < 2; i++) cmp("drain_empty", i, PL'(s_empty[i]), PL'(1'b1));
    endtask

    vec_t   t1 [18];
    vec_t   t2 [5];
    group_t g;
    int     sent [2];
    int     cyc;

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0);
        din[0] = '0;
        din[1] = '0;
        pos    = '{0, 0};
        pops   = '{0, 0};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            cmp("rst_empty", i, PL'(s_empty[i]), PL'(1'b1));
            cmp("rst_val",   i, PL'(s_val[i]),   PL'(1'b0));
        end

        // Single group, rdy held high: 16 beats 0..7,16..23, last on beat 16 only.
        t1[0] = '{wr: 1'b1, rdy: 1'b1, e_ack: 1'b1, e_full: 1'b0, e_val: 1'b0, e_last: 1'b0,
                  e_dout: '0, e_cnt: 0};
        for (int k = 0; k < 16; k++)
            t1[k+1] = '{wr: 1'b0, rdy: 1'b1, e_ack: 1'b0, e_full: 1'b0, e_val: 1'b1,
                        e_last: (k == 15), e_dout: PL'((k < 8) ? k : k + 8), e_cnt: 1};
        t1[17] = '{wr: 1'b0, rdy: 1'b1, e_ack: 1'b0, e_full: 1'b0, e_val: 1'b0, e_last: 1'b0,
                   e_dout: '0, e_cnt: 0};
        for (int b = 0; b < W; b++)
            for (int u = 0; u < N; u++) g[b][u] = PL'(16 * u + b);
        din[0] = g;
        din[1] = g;
        for (int k = 0; k < 18; k++) begin
            set_in(t1[k].wr, t1[k].rdy, 1'b0);
            step();
            cmp("t1_ack",  0, PL'(s_ack[0]),  PL'(t1[k].e_ack));
            cmp("t1_val",  0, PL'(s_val[0]),  PL'(t1[k].e_val));
            cmp("t1_last", 0, PL'(s_last[0]), PL'(t1[k].e_last));
            cmp("t1_dout", 0, s_dout[0],      t1[k].e_dout);
            cmp("t1_cnt",  0, PL'(s_cnt[0]),  PL'(t1[k].e_cnt));
        end

        // Five back-to-back writes with rdy low: the fifth is refused while full.
        for (int k = 0; k < 5; k++)
            t2[k] = '{wr: 1'b1, rdy: 1'b0, e_ack: (k < 4), e_full: (k == 4), e_val: (k > 0),
                      e_last: 1'b0, e_dout: '0, e_cnt: k};
        for (int k = 0; k < 5; k++) begin
            din[0] = tag_group(k);
            din[1] = tag_group(k);
            set_in(t2[k].wr, t2[k].rdy, 1'b0);
            step();
            cmp("t2_ack",  0, PL'(s_ack[0]),  PL'(t2[k].e_ack));
            cmp("t2_full", 0, PL'(s_full[0]), PL'(t2[k].e_full));
            cmp("t2_val",  0, PL'(s_val[0]),  PL'(t2[k].e_val));
            cmp("t2_dout", 0, s_dout[0],      t2[k].e_dout);
            cmp("t2_cnt",  0, PL'(s_cnt[0]),  PL'(t2[k].e_cnt));
        end
        set_in(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            for (int p = 0; p < BEATS; p++) begin
                step();
                cmp("t2_drain", 0, s_dout[0], PL'((k << 8) | ((p / W) << 4) | (p % W)));
            end
        drain();

        // Write coinciding with the last-beat pop at cnt=2: accepted, count unchanged.
        set_in(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            din[0] = rand_group();
            din[1] = din[0];
            step();
        end
        set_in(1'b0, 1'b1, 1'b0);
        repeat (BEATS - 1) step();
        din[0] = rand_group();
        din[1] = din[0];
        set_in(1'b1, 1'b1, 1'b0);
        step();
        cmp("t4a_last", 0, PL'(s_last[0]), PL'(1'b1));
        cmp("t4a_ack",  0, PL'(s_ack[0]),  PL'(1'b1));
        set_in(1'b0, 1'b0, 1'b0);
        step();
        cmp("t4a_cnt",  0, PL'(s_cnt[0]),  PL'(2));
        drain();

        // Same event at cnt=DEPTH: refused that cycle, accepted on the next.
        set_in(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            din[0] = rand_group();
            din[1] = din[0];
            step();
        end
        set_in(1'b0, 1'b1, 1'b0);
        repeat (BEATS - 1) step();
        din[0] = rand_group();
        din[1] = din[0];
        set_in(1'b1, 1'b1, 1'b0);
        step();
        cmp("t4b_last", 0, PL'(s_last[0]), PL'(1'b1));
        cmp("t4b_ack0", 0, PL'(s_ack[0]),  PL'(1'b0));
        step();
        cmp("t4b_ack1", 0, PL'(s_ack[0]),  PL'(1'b1));
        drain();

        // Clear at beat 5 with a pending write; next group starts at unit 0, bit 0.
        din[0] = rand_group();
        din[1] = din[0];
        set_in(1'b1, 1'b0, 1'b0);
        step();
        set_in(1'b0, 1'b1, 1'b0);
        repeat (5) step();
        din[0] = rand_group();
        din[1] = din[0];
        set_in(1'b1, 1'b1, 1'b1);
        step();
        for (int i = 0; i < 2; i++) cmp("t6_ack", i, PL'(s_ack[i]), PL'(1'b0));
        set_in(1'b0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 2; i++) begin
            cmp("t6_cnt", i, PL'(s_cnt[i]), PL'(0));
            cmp("t6_val", i, PL'(s_val[i]), PL'(1'b0));
        end
        g      = rand_group();
        din[0] = g;
        din[1] = g;
        set_in(1'b1, 1'b0, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b0);
        step();
        cmp("t6_first", 0, s_dout[0], g[0][0]);
        drain();

        // Ten groups per instance through the FIFO with random back-pressure.
        pops = '{0, 0};
        sent = '{0, 0};
        for (int i = 0; i < 2; i++) din[i] = rand_group();
        clr = 1'b0;
        cyc = 0;
        while (!(sent[0] == 10 && sent[1] == 10 && msize(0) == 0 && msize(1) == 0)
               && cyc < 2000) begin
            for (int i = 0; i < 2; i++) wr_req[i] = (sent[i] < 10);
            rdy = ($urandom_range(3, 0) != 0);
            step();
            for (int i = 0; i < 2; i++)
                if (s_ack[i]) begin
                    sent[i]++;
                    din[i] = rand_group();
                end
            cyc++;
        end
        for (int i = 0; i < 2; i++) cmp("t5_groups_out", i, PL'(pops[i]), PL'(10));
        drain();

        // Free-running random traffic with occasional clears.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) wr_req[i] = ($urandom_range(2, 0) != 0);
            rdy = $urandom_range(1, 0) != 0;
            clr = ($urandom_range(49, 0) == 0);
            step();
            for (int i = 0; i < 2; i++)
                if (s_ack[i]) din[i] = rand_group();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
